quad_step_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 15 +
 rtl/quad_chan_filter.sv | 40 ++++
 rtl/quad_step_decoder.sv | 55 +++++
 tb/tb_quad_step_decoder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: phase encodings, direction levels, default sizing and forward-sequence helper
// Shared by quad_chan_filter and quad_step_decoder.
package quad_pkg;
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF = 3;
    function automatic logic [1:0] next_fwd(input logic [1:0] ph);
        return ph == PH_00 ? PH_10 : ph == PH_10 ? PH_11 : ph == PH_11 ? PH_01 : PH_00;
    endfunction
endpackage

// File: rtl/quad_chan_filter.sv
// quad_chan_filter: per-channel synchroniser chain plus persistence glitch filter
// Ports: clk, rstn (async, active-high), i_raw (asynchronous pin),
//        i_init (load filter straight from synchroniser), o_filt (accepted level).
module quad_chan_filter
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_raw,
    input  logic i_init,
    output logic o_filt
);
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   w_sync;
    assign w_sync = r_sync[SYNC_STAGES-1];
    // A change is accepted only after it has been seen FILT_LEN consecutive cycles.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_sync <= '0;
            r_cnt  <= '0;
            o_filt <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (i_init) begin
                o_filt <= w_sync;
                r_cnt  <= '0;
            end else if (w_sync != o_filt) begin
                o_filt <= r_cnt == CW'(FILT_LEN - 1) ? w_sync : o_filt;
                r_cnt  <= r_cnt == CW'(FILT_LEN - 1) ? '0 : r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature A/B to registered step strobe, direction level and sticky error
// Ports: clk, rstn (async, active-high), a_in/b_in (raw phases), err_clr (sync clear of err),
//        step (one-cycle strobe), up_down (1 = up), err (sticky illegal-jump flag).
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clr,
    output logic step,
    output logic up_down,
    output logic err
);
    localparam int IW = $clog2(SYNC_STAGES + FILT_LEN + 1);
    logic [IW-1:0] r_init;
    logic          r_blk;
    logic [1:0]    r_ph_d;
    logic [1:0]    w_ph;
    logic [1:0]    w_diff;
    logic          w_init;
    logic          w_one;
    assign w_init = r_init != '0;
    assign w_diff = w_ph ^ r_ph_d;
    assign w_one  = w_diff == 2'b01 || w_diff == 2'b10;
    quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fa (
        .clk(clk), .rstn(rstn), .i_raw(a_in), .i_init(w_init), .o_filt(w_ph[1])
    );
    quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fb (
        .clk(clk), .rstn(rstn), .i_raw(b_in), .i_init(w_init), .o_filt(w_ph[0])
    );
    // r_blk lags the init window by one cycle so the delayed phase has caught up
    // with the last directly-loaded value before any comparison is trusted.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_init  <= IW'(SYNC_STAGES + FILT_LEN);
            r_blk   <= 1'b1;
            r_ph_d  <= PH_00;
            step    <= 1'b0;
            up_down <= DIR_UP;
            err     <= 1'b0;
        end else begin
            r_init  <= w_init ? r_init - 1'b1 : r_init;
            r_blk   <= w_init;
            r_ph_d  <= w_ph;
            step    <= !r_blk && w_one;
            up_down <= (!r_blk && w_one) ? (w_ph == next_fwd(r_ph_d) ? DIR_UP : DIR_DN) : up_down;
            err     <= (!r_blk && w_diff == 2'b11) ? 1'b1 : err_clr ? 1'b0 : err;
        end
    end
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed checks of reset, forward/reverse steps, glitches, errors, mid-run reset
module tb_quad_step_decoder;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic a_in = 1'b0;
    logic b_in = 1'b0;
    logic err_clr = 1'b0;
    logic step, up_down, err;
    int n_tests = 0;
    int n_fail = 0;
    int n_cnt, n_first;
    logic dir_first;

    always #5 clk = ~clk;

    quad_step_decoder dut (
        .clk(clk), .rstn(rstn), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
        .step(step), .up_down(up_down), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observe n cycles on the falling edge; optionally drop a_in after cycle drop_a.
    task automatic win(input int n, input int drop_a);
        n_cnt = 0;
        n_first = 0;
        dir_first = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (step) begin
                n_cnt++;
                if (n_first == 0) begin
                    n_first = i;
                    dir_first = up_down;
                end
            end
            if (i == drop_a) a_in = 1'b0;
        end
    endtask

    task automatic move(input logic a, input logic b, input logic dir, input string tag);
        a_in = a;
        b_in = b;
        win(10, 0);
        chk({tag, " steps"}, n_cnt, 1);
        chk({tag, " latency"}, n_first, 6);
        chk({tag, " dir"}, dir_first, dir);
        chk({tag, " err"}, err, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_in = i[0];
            b_in = i[1];
            chk("rst step", step, 0);
            chk("rst dir", up_down, 1);
            chk("rst err", err, 0);
        end
        @(negedge clk);
        a_in = 1'b0;
        b_in = 1'b0;
        rstn = 1'b0;
        win(20, 0);
        chk("idle steps", n_cnt, 0);
        chk("idle err", err, 0);

        move(1'b1, 1'b0, 1'b1, "fwd 00-10");
        move(1'b1, 1'b1, 1'b1, "fwd 10-11");
        move(1'b0, 1'b1, 1'b1, "fwd 11-01");
        move(1'b0, 1'b0, 1'b1, "fwd 01-00");

        move(1'b0, 1'b1, 1'b0, "rev 00-01");
        move(1'b1, 1'b1, 1'b0, "rev 01-11");
        move(1'b1, 1'b0, 1'b0, "rev 11-10");
        move(1'b0, 1'b0, 1'b0, "rev 10-00");

        a_in = 1'b1;
        win(12, 2);
        chk("glitch2 steps", n_cnt, 0);
        chk("glitch2 err", err, 0);
        chk("glitch2 dir", up_down, 0);

        a_in = 1'b1;
        win(16, 3);
        chk("pulse3 steps", n_cnt, 2);
        chk("pulse3 latency", n_first, 6);
        chk("pulse3 first dir", dir_first, 1);
        chk("pulse3 final dir", up_down, 0);
        chk("pulse3 err", err, 0);

        a_in = 1'b1;
        b_in = 1'b1;
        win(10, 0);
        chk("illegal steps", n_cnt, 0);
        chk("illegal err", err, 1);
        chk("illegal dir", up_down, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", err, 0);

        a_in = 1'b0;
        b_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-jump err", err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("set beats clr err", err, 1);
        chk("set beats clr step", step, 0);
        @(negedge clk);
        chk("err sticky", err, 1);

        a_in = 1'b1;
        b_in = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("async rst err", err, 0);
        chk("async rst dir", up_down, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid rst step", step, 0);
            chk("mid rst err", err, 0);
        end
        rstn = 1'b0;
        win(20, 0);
        chk("post rst steps", n_cnt, 0);
        chk("post rst err", err, 0);
        chk("post rst dir", up_down, 1);
        move(1'b0, 1'b1, 1'b1, "post rst 11-01");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
